bcd_serial_adder: RTL and testbench
===================================

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 Parameter DIGITS, default 4, SHALL set the number of BCD digits per operand; legal range 1..8.
REQ-002 Clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Reset  input  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-004 start  input  1  SHALL request one addition; it is honoured only in IDLE.
REQ-005 X  input  4*DIGITS  SHALL carry operand A, one BCD digit per nibble, digit 0 in bits [3:0].
REQ-006 Y  input  4*DIGITS  SHALL carry operand B, with the same packing as X.
REQ-007 cin  input  1  SHALL be the decimal carry-in added at digit 0.
REQ-008 S  output  4*DIGITS  SHALL carry the registered BCD sum, with the same packing as X.
REQ-009 cout  output  1  SHALL carry the registered decimal carry-out of the top digit.
REQ-010 busy  output  1  SHALL be high while an addition is in progress.
REQ-011 done  output  1  SHALL be a single-cycle completion pulse.
REQ-012 err  output  1  SHALL be a registered flag meaning an operand digit exceeded 9.
REQ-013 HEX  output  7*(DIGITS+1)  SHALL drive active-low seven-segment patterns, bit 0 = segment a, digit i in bits [7i+6:7i], digit DIGITS = cout.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-015 IDLE with start=1 SHALL latch X, Y and cin into internal registers, clear the digit index, and move to ADD.
REQ-016 start while in ADD or DONE SHALL be ignored, with no effect on state or latched operands.
REQ-017 ADD SHALL process exactly one digit per cycle, LSD first: t = Xi + Yi + c (5-bit); if t>9 then Si = t-10, c = 1, else Si = t, c = 0.
REQ-018 After digit DIGITS-1 is processed, ADD SHALL move to DONE and register cout = final c.
REQ-019 DONE SHALL assert done for one cycle, then return to IDLE unconditionally.
REQ-020 Timing: with start sampled at edge k, busy SHALL be high for cycles k+1..k+DIGITS and done SHALL be high in cycle k+DIGITS+1 only.
REQ-021 Any latched digit of X or Y >9 SHALL set err=1 when done is asserted, force S and cout to 0, and keep the same latency.
REQ-022 S, cout and err SHALL hold their values from done until the next accepted start.
REQ-023 On an accepted start, err SHALL clear immediately, and S and cout SHALL update digit by digit as ADD proceeds.
REQ-024 HEX SHALL decode each S digit 0..9 to standard decimal glyphs, using the team BCD-to-segment table.
REQ-025 The HEX carry digit SHALL show "1" when cout=1 and blank (all ones) when cout=0.
REQ-026 All HEX digits SHALL be blank (all ones) while err=1.
REQ-027 cin SHALL be treated as 0 or 1 only; no other carry source exists.

Reset
REQ-028 Reset=1 SHALL force IDLE, S=0, cout=0, busy=0, done=0, err=0, and clear the digit index and latched operands.
REQ-029 In the reset state HEX SHALL show "0" in every sum digit and a blank carry digit.
REQ-030 Reset asserted during ADD or DONE SHALL abort the operation with no done pulse, and outputs SHALL take reset values on the next edge.
REQ-031 Reset and start asserted in the same cycle SHALL resolve in favour of Reset.

Verification
REQ-032 DIGITS=4, X=0x0999, Y=0x0001, cin=0 -> S=0x1000, cout=0, err=0, done exactly 5 cycles after the start edge.
REQ-033 X=0x4999, Y=0x5000, cin=1 -> S=0x0000, cout=1, carry HEX digit = "1".
REQ-034 X=0x0A23, Y=0x0001 -> err=1, S=0, cout=0, all HEX blank, done still at cycle 5.
REQ-035 Pulse start again at cycles 2 and 4 of an active addition -> no effect, single done, result matches the first operands.
REQ-036 Assert Reset in cycle 3 of ADD -> no done pulse, S=0, busy=0 next cycle; a fresh start then completes correctly.
REQ-037 DIGITS=1, X=0x9, Y=0x9, cin=1 -> S=0x9, cout=1, done 2 cycles after the start edge.

Source files
------------

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: multi-cycle BCD adder, one digit per clock, LSD first, with seven-segment output.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    start,
    input  logic [4*DIGITS-1:0]     X,
    input  logic [4*DIGITS-1:0]     Y,
    input  logic                    cin,
    output logic [4*DIGITS-1:0]     S,
    output logic                    cout,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [7*(DIGITS+1)-1:0] HEX
);
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t state, nxt;
    logic [4*DIGITS-1:0] x_q, y_q;
    logic                c_q;
    logic [3:0]          idx;
    logic [3:0]          xd, yd, sd;
    logic [4:0]          t, tm;
    logic                gt, bad, last;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        xd  = '0;
        yd  = '0;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == 4'(i)) begin
                xd = x_q[4*i +: 4];
                yd = y_q[4*i +: 4];
            end
            bad = bad | (x_q[4*i +: 4] > 4'd9) | (y_q[4*i +: 4] > 4'd9);
        end
        t    = {1'b0, xd} + {1'b0, yd} + {4'b0, c_q};
        tm   = t - 5'd10;
        gt   = t > 5'd9;
        sd   = gt ? tm[3:0] : t[3:0];
        last = idx == 4'(DIGITS - 1);
    end

    always_ff @(posedge Clock) begin
        if (Reset)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt  = state;
        nxt  = (state == IDLE) ? (start ? ADD : IDLE) :
               (state == ADD)  ? (last ? DONE : ADD) : IDLE;
        busy = state == ADD;
        done = state == DONE;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            x_q  <= '0;
            y_q  <= '0;
            c_q  <= 1'b0;
            idx  <= '0;
            S    <= '0;
            cout <= 1'b0;
            err  <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                x_q <= X;
                y_q <= Y;
                c_q <= cin;
                idx <= '0;
                err <= 1'b0;
            end
        end else if (state == ADD) begin
            for (int i = 0; i < DIGITS; i++)
                if (idx == 4'(i))
                    S[4*i +: 4] <= bad ? 4'd0 : sd;
            c_q <= gt;
            idx <= idx + 4'd1;
            // An invalid digit anywhere poisons the whole result at completion
            if (last) begin
                cout <= bad ? 1'b0 : gt;
                err  <= bad;
                if (bad)
                    S <= '0;
            end
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_hex
        assign HEX[7*g +: 7] = err ? 7'b1111111 : seg(S[4*g +: 4]);
    end
    assign HEX[7*DIGITS +: 7] = (err || !cout) ? 7'b1111111 : seg(4'd1);
endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: randomized check of bcd_serial_adder against a decimal-arithmetic model.
module tb_bcd_serial_adder;
    localparam int D  = 4;
    localparam int W  = 4 * D;
    localparam int HW = 7 * (D + 1);

    logic          Clock = 1'b0;
    logic          Reset, start, cin, cout, busy, done, err;
    logic [W-1:0]  X, Y, S;
    logic [HW-1:0] HEX;
    logic          start1, cin1, cout1, busy1, done1, err1;
    logic [3:0]    X1, Y1, S1;
    logic [13:0]   HEX1;

    int checks = 0;
    int errors = 0;
    logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    bcd_serial_adder #(.DIGITS(D)) dut (
        .Clock(Clock), .Reset(Reset), .start(start), .X(X), .Y(Y), .cin(cin),
        .S(S), .cout(cout), .busy(busy), .done(done), .err(err), .HEX(HEX)
    );
    bcd_serial_adder #(.DIGITS(1)) dut1 (
        .Clock(Clock), .Reset(Reset), .start(start1), .X(X1), .Y(Y1), .cin(cin1),
        .S(S1), .cout(cout1), .busy(busy1), .done(done1), .err(err1), .HEX(HEX1)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic c, input int d,
                                  output logic [31:0] s, output logic co, output logic e);
        int a = 0, b = 0, p = 1, sum;
        e = 1'b0;
        for (int i = 0; i < d; i++) begin
            if (x[4*i +: 4] > 9 || y[4*i +: 4] > 9) e = 1'b1;
            a += int'(x[4*i +: 4]) * p;
            b += int'(y[4*i +: 4]) * p;
            p *= 10;
        end
        sum = a + b + int'(c);
        co  = sum >= p;
        sum = sum % p;
        s   = '0;
        for (int i = 0; i < d; i++) begin
            s[4*i +: 4] = 4'(sum % 10);
            sum /= 10;
        end
        if (e) begin
            s  = '0;
            co = 1'b0;
        end
    endfunction

    function automatic logic [63:0] hex_of(input logic [31:0] s, input logic co, input logic e, input int d);
        logic [63:0] r = '0;
        for (int i = 0; i < d; i++)
            r[7*i +: 7] = e ? 7'h7F : glyph[s[4*i +: 4]];
        r[7*d +: 7] = (e || !co) ? 7'h7F : glyph[1];
        return r;
    endfunction

    function automatic logic [31:0] rand_bcd(input int d);
        logic [31:0] v = '0;
        for (int i = 0; i < d; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 4) == 0) v[4*$urandom_range(0, d-1) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit poke, input string tag);
        logic [31:0] es;
        logic        eco, ee;
        int          nb = 0, nd = 0, dc = -1;
        model(32'(a), 32'(b), c, D, es, eco, ee);
        @(negedge Clock);
        X = a; Y = b; cin = c; start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        for (int n = 1; n <= D + 3; n++) begin
            if (n == 1) check({tag, " err_clear"}, 64'(err), 64'(0));
            if (busy) nb++;
            if (done) begin nd++; dc = n; end
            if (n == D + 1) begin
                check({tag, " S"}, 64'(S), 64'(es));
                check({tag, " cout"}, 64'(cout), 64'(eco));
                check({tag, " err"}, 64'(err), 64'(ee));
                check({tag, " HEX"}, 64'(HEX), hex_of(es, eco, ee, D));
            end
            start = poke && (n == 2 || n == 4);
            if (start) begin X = W'($urandom); Y = W'($urandom); cin = ~c; end
            @(negedge Clock);
        end
        start = 1'b0;
        check({tag, " busy_cycles"}, 64'(nb), 64'(D));
        check({tag, " done_count"}, 64'(nd), 64'(1));
        check({tag, " done_cycle"}, 64'(dc), 64'(D + 1));
        check({tag, " S_hold"}, 64'(S), 64'(es));
    endtask

    task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic c, input string tag);
        logic [31:0] es;
        logic        eco, ee;
        int          nd = 0, dc = -1;
        model(32'(a), 32'(b), c, 1, es, eco, ee);
        @(negedge Clock);
        X1 = a; Y1 = b; cin1 = c; start1 = 1'b1;
        @(negedge Clock);
        start1 = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            if (done1) begin nd++; dc = n; end
            if (n == 2) begin
                check({tag, " S"}, 64'(S1), 64'(es));
                check({tag, " cout"}, 64'(cout1), 64'(eco));
                check({tag, " err"}, 64'(err1), 64'(ee));
                check({tag, " HEX"}, 64'(HEX1), hex_of(es, eco, ee, 1));
            end
            @(negedge Clock);
        end
        check({tag, " done_count"}, 64'(nd), 64'(1));
        check({tag, " done_cycle"}, 64'(dc), 64'(2));
    endtask

    initial begin
        int nd;
        Reset = 1'b1; start = 1'b0; cin = 1'b0; X = '0; Y = '0;
        start1 = 1'b0; cin1 = 1'b0; X1 = '0; Y1 = '0;
        repeat (3) @(negedge Clock);
        check("rst S", 64'(S), 64'(0));
        check("rst flags", 64'({cout, busy, done, err}), 64'(0));
        check("rst HEX", 64'(HEX), hex_of(0, 1'b0, 1'b0, D));
        check("rst HEX1", 64'(HEX1), hex_of(0, 1'b0, 1'b0, 1));
        start = 1'b1;
        @(negedge Clock);
        Reset = 1'b0; start = 1'b0;
        check("rst_start busy", 64'(busy), 64'(0));

        run_op(16'h0999, 16'h0001, 1'b0, 1'b0, "ripple");
        run_op(16'h4999, 16'h5000, 1'b1, 1'b0, "carry_out");
        run_op(16'h0A23, 16'h0001, 1'b0, 1'b0, "bad_digit");
        run_op(16'h1234, 16'h8765, 1'b1, 1'b1, "start_ignored");

        @(negedge Clock);
        X = 16'h5555; Y = 16'h5555; cin = 1'b1; start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        check("abort S", 64'(S), 64'(0));
        check("abort busy", 64'(busy), 64'(0));
        check("abort cout", 64'(cout), 64'(0));
        nd = 0;
        repeat (4) begin
            if (done) nd++;
            @(negedge Clock);
        end
        check("abort no_done", 64'(nd), 64'(0));
        run_op(16'h2718, 16'h3141, 1'b0, 1'b0, "after_abort");

        for (int i = 0; i < 30; i++)
            run_op(W'(rand_bcd(D)), W'(rand_bcd(D)), 1'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0), "rand");

        run1(4'h9, 4'h9, 1'b1, "d1_max");
        for (int i = 0; i < 10; i++)
            run1(4'(rand_bcd(1)), 4'(rand_bcd(1)), 1'($urandom_range(0, 1)), "d1_rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
